hack_rom_loader: RTL

Byte-stream program loader that writes the instruction ROM read by the Hack CPU and owns the CPU's reset. It takes framed bytes from the UART receiver, assembles 16-bit instruction words, and writes them sequentially from ROM address 0. It holds the CPU in reset during a load and releases it only after a complete, valid frame. It is the writer side of the CPU's instruction-fetch path.

---
 rtl/hack_rom_loader.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/hack_rom_loader.sv
// Framed byte-stream loader for the Hack instruction ROM; holds the CPU in reset while loading.
// Optional trailing checksum byte is compiled in with `define LOADER_CHECKSUM_EN.
module hack_rom_loader #(
  parameter int unsigned MAX_WORDS      = 32768,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        boot_skip,
  output logic        rom_we,
  output logic [14:0] rom_addr,
  output logic [15:0] rom_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        err,
  output logic [15:0] words_loaded
);

  localparam int unsigned   CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    SYNC    = 8'hA5;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]   MAX_LEN = 17'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_H, S_LEN_L, S_DATA_H, S_DATA_L, S_CSUM, S_RUN, S_ERR
  } state_t;
  localparam state_t S_DONE = S_CSUM;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_H, S_LEN_L, S_DATA_H, S_DATA_L, S_RUN, S_ERR
  } state_t;
  localparam state_t S_DONE = S_RUN;
`endif

  state_t          state_q, state_d;
  logic [15:0]     len_q, len_d;
  logic [14:0]     addr_q, addr_d;
  logic [15:0]     wl_q, wl_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cpu_reset_q, cpu_reset_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic            in_frame_q, in_frame_d;
  logic [15:0]     len_rx;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  assign len_rx = {len_q[15:8], rx_data};

  always_comb begin
`ifdef LOADER_CHECKSUM_EN
    in_frame_q = state_q inside {S_LEN_H, S_LEN_L, S_DATA_H, S_DATA_L, S_CSUM};
`else
    in_frame_q = state_q inside {S_LEN_H, S_LEN_L, S_DATA_H, S_DATA_L};
`endif
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    wl_d    = wl_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    // Address/count advance at the end of the write cycle; LEN_L below may override.
    if (we_q) begin
      addr_d = addr_q + 15'd1;
      wl_d   = wl_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == SYNC) state_d = S_LEN_H;
        end else if (boot_skip) begin
          state_d = S_RUN;
        end
      end
      S_LEN_H: begin
        if (rx_valid) begin
          len_d[15:8] = rx_data;
          state_d     = S_LEN_L;
        end
      end
      S_LEN_L: begin
        if (rx_valid) begin
          len_d[7:0] = rx_data;
          addr_d     = '0;
          wl_d       = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
          if ({1'b0, len_rx} > MAX_LEN) state_d = S_ERR;
          else if (len_rx == 16'd0)     state_d = S_DONE;
          else                          state_d = S_DATA_H;
        end
      end
      S_DATA_H: begin
        if (rx_valid) begin
          wdata_d[15:8] = rx_data;
`ifdef LOADER_CHECKSUM_EN
          csum_d        = csum_q + rx_data;
`endif
          state_d       = S_DATA_L;
        end
      end
      S_DATA_L: begin
        if (rx_valid) begin
          wdata_d[7:0] = rx_data;
          we_d         = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_d       = csum_q + rx_data;
`endif
          if (wl_q + 16'd1 == len_q) state_d = S_DONE;
          else                       state_d = S_DATA_H;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (rx_valid) state_d = (rx_data == csum_q) ? S_RUN : S_ERR;
      end
`endif
      S_RUN, S_ERR: begin
        if (rx_valid && rx_data == SYNC) state_d = S_LEN_H;
      end
      default: state_d = S_IDLE;
    endcase

    // A strobe on the expiry edge wins over the timeout.
    if (in_frame_q && !rx_valid) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == TO_LAST) state_d = S_ERR;
    end
  end

  always_comb begin
`ifdef LOADER_CHECKSUM_EN
    in_frame_d = state_d inside {S_LEN_H, S_LEN_L, S_DATA_H, S_DATA_L, S_CSUM};
`else
    in_frame_d = state_d inside {S_LEN_H, S_LEN_L, S_DATA_H, S_DATA_L};
`endif
    busy_d = in_frame_d;
    err_d  = (state_d == S_ERR);
    // Rises as soon as RUN is left, falls one cycle after RUN is entered so the last write lands first.
    cpu_reset_d = (state_q != S_RUN) || (state_d != S_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      addr_q      <= '0;
      wl_q        <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      wl_q        <= wl_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign rom_we       = we_q;
  assign rom_addr     = addr_q;
  assign rom_wdata    = wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign busy         = busy_q;
  assign err          = err_q;
  assign words_loaded = wl_q;

endmodule
